// File: rtl/slc3_isdu_param.sv
// SLC-3 instruction sequencer/decoder with a programmable SRAM wait counter.
// Moore machine: every control output is a pure function of the current state
// (and the IR bits that pick operands), and defaults to 0 each cycle.
module slc3_isdu_param #(
  parameter int unsigned MEM_WAIT = 2,    // SRAM access cycles, must be >= 1
  parameter bit          PAUSE_EN = 1'b1  // 1: opcode 1101 pauses, 0: NOP
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       run_i,
  input  logic       continue_i,
  input  logic [3:0] opcode_i,
  input  logic       ir_5_i,
  input  logic       ir_11_i,
  input  logic       ben_i,
  output logic       ld_mar_o,
  output logic       ld_mdr_o,
  output logic       ld_ir_o,
  output logic       ld_ben_o,
  output logic       ld_cc_o,
  output logic       ld_reg_o,
  output logic       ld_pc_o,
  output logic       ld_led_o,
  output logic       gate_pc_o,
  output logic       gate_mdr_o,
  output logic       gate_alu_o,
  output logic       gate_marmux_o,
  output logic [1:0] pcmux_o,
  output logic       drmux_o,
  output logic       sr1mux_o,
  output logic       sr2mux_o,
  output logic       addr1mux_o,
  output logic [1:0] addr2mux_o,
  output logic [1:0] aluk_o,
  output logic       mem_oe_o,
  output logic       mem_we_o,
  output logic       busy_o
);

  localparam int unsigned CntW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MEM_WAIT - 1);

  typedef enum logic [4:0] {
    StHalted, StF18, StFMem, StF35, StD32,
    StAdd, StAnd, StNot, StE22, StJmp,
    StE04, StE21, StE20,
    StE06, StLMem, StE27,
    StE07, StE23, StSMem,
    StPause1, StPause2
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mem_last;

  // Last cycle of an SRAM access; the counter is 0 on entry to every memory state.
  assign mem_last = (cnt_q == CntLast);

  // State and wait-counter registers; Reset overrides everything, even mid-access.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StHalted;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      StHalted: if (run_i) state_d = StF18;
      StF18:    state_d = StFMem;
      StFMem: begin
        if (mem_last) state_d = StF35;
        else          cnt_d   = cnt_q + 1'b1;
      end
      StF35:    state_d = StD32;
      StD32: begin
        unique case (opcode_i)
          4'b0001: state_d = StAdd;
          4'b0101: state_d = StAnd;
          4'b1001: state_d = StNot;
          4'b0000: state_d = ben_i ? StE22 : StF18;
          4'b1100: state_d = StJmp;
          4'b0100: state_d = StE04;
          4'b0110: state_d = StE06;
          4'b0111: state_d = StE07;
          4'b1101: state_d = PAUSE_EN ? StPause1 : StF18;
          default: state_d = StF18;
        endcase
      end
      StE04:    state_d = ir_11_i ? StE21 : StE20;
      StE06:    state_d = StLMem;
      StLMem: begin
        if (mem_last) state_d = StE27;
        else          cnt_d   = cnt_q + 1'b1;
      end
      StE07:    state_d = StE23;
      StE23:    state_d = StSMem;
      StSMem: begin
        if (mem_last) state_d = StF18;
        else          cnt_d   = cnt_q + 1'b1;
      end
      StPause1: if (continue_i)  state_d = StPause2;
      StPause2: if (!continue_i) state_d = StF18;
      // Single-cycle execute states all return to fetch.
      StAdd, StAnd, StNot, StE22, StJmp, StE21, StE20, StE27: state_d = StF18;
      default:  state_d = StHalted;
    endcase
  end

  // Control outputs decoded from the current state.
  always_comb begin
    ld_mar_o      = 1'b0;
    ld_mdr_o      = 1'b0;
    ld_ir_o       = 1'b0;
    ld_ben_o      = 1'b0;
    ld_cc_o       = 1'b0;
    ld_reg_o      = 1'b0;
    ld_pc_o       = 1'b0;
    ld_led_o      = 1'b0;
    gate_pc_o     = 1'b0;
    gate_mdr_o    = 1'b0;
    gate_alu_o    = 1'b0;
    gate_marmux_o = 1'b0;
    pcmux_o       = 2'b00;
    drmux_o       = 1'b0;
    sr1mux_o      = 1'b0;
    sr2mux_o      = 1'b0;
    addr1mux_o    = 1'b0;
    addr2mux_o    = 2'b00;
    aluk_o        = 2'b00;
    mem_oe_o      = 1'b0;
    mem_we_o      = 1'b0;
    busy_o        = 1'b1;
    unique case (state_q)
      StHalted: busy_o = 1'b0;
      StF18: begin
        // Old PC goes to MAR while PC+1 is loaded on the same edge.
        gate_pc_o = 1'b1;
        ld_mar_o  = 1'b1;
        ld_pc_o   = 1'b1;
        pcmux_o   = 2'b00;
      end
      StFMem: begin
        mem_oe_o = 1'b1;
        ld_mdr_o = mem_last;
      end
      StF35: begin
        gate_mdr_o = 1'b1;
        ld_ir_o    = 1'b1;
      end
      StD32: ld_ben_o = 1'b1;
      StAdd, StAnd: begin
        sr1mux_o   = 1'b1;
        sr2mux_o   = ir_5_i;
        aluk_o     = (state_q == StAnd) ? 2'b01 : 2'b00;
        gate_alu_o = 1'b1;
        ld_reg_o   = 1'b1;
        ld_cc_o    = 1'b1;
      end
      StNot: begin
        sr1mux_o   = 1'b1;
        aluk_o     = 2'b10;
        gate_alu_o = 1'b1;
        ld_reg_o   = 1'b1;
        ld_cc_o    = 1'b1;
      end
      StE22: begin
        addr1mux_o = 1'b0;
        addr2mux_o = 2'b10;
        pcmux_o    = 2'b10;
        ld_pc_o    = 1'b1;
      end
      StJmp: begin
        sr1mux_o   = 1'b1;
        aluk_o     = 2'b11;
        gate_alu_o = 1'b1;
        pcmux_o    = 2'b01;
        ld_pc_o    = 1'b1;
      end
      StE04: begin
        // Return address into R7 before PC is overwritten.
        gate_pc_o = 1'b1;
        drmux_o   = 1'b1;
        ld_reg_o  = 1'b1;
      end
      StE21: begin
        addr1mux_o = 1'b0;
        addr2mux_o = 2'b11;
        pcmux_o    = 2'b10;
        ld_pc_o    = 1'b1;
      end
      StE20: begin
        sr1mux_o   = 1'b1;
        addr1mux_o = 1'b1;
        addr2mux_o = 2'b00;
        pcmux_o    = 2'b10;
        ld_pc_o    = 1'b1;
      end
      StE06, StE07: begin
        sr1mux_o      = 1'b1;
        addr1mux_o    = 1'b1;
        addr2mux_o    = 2'b01;
        gate_marmux_o = 1'b1;
        ld_mar_o      = 1'b1;
      end
      StLMem: begin
        mem_oe_o = 1'b1;
        ld_mdr_o = mem_last;
      end
      StE27: begin
        gate_mdr_o = 1'b1;
        ld_reg_o   = 1'b1;
        ld_cc_o    = 1'b1;
      end
      StE23: begin
        // Store data is read from IR[11:9] and passed through the ALU.
        sr1mux_o   = 1'b0;
        aluk_o     = 2'b11;
        gate_alu_o = 1'b1;
        ld_mdr_o   = 1'b1;
      end
      StSMem: mem_we_o = 1'b1;
      StPause1: begin
        ld_led_o = 1'b1;
        busy_o   = 1'b0;
      end
      StPause2: busy_o = 1'b0;
      default:  busy_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_slc3_isdu_param.sv
// Bench for slc3_isdu_param: table of opcode vectors with expected state-tag
// sequences, expanded into per-cycle control words on a scoreboard queue.
module tb_slc3_isdu_param;

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic       drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux, aluk;
    logic       mem_oe, mem_we, busy;
  } ctl_t;

  typedef enum int {
    TH, T18, TFM, TFML, T35, T32, TADD, TAND, TNOT, TE22, TJMP, TE04, TE21, TE20,
    TE06, TLM, TLML, TE27, TE07, TE23, TSM, TP1, TP2, TLMX, TSMX
  } tag_e;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic       ir5, ir11, ben;
    tag_e       ex[4];
    int         n_ex;
    bit         to_fetch;
  } vec_t;

  logic       Clk, Reset, run, cont, ir5, ir11, ben;
  logic [3:0] opcode;
  ctl_t       oa, ob;
  bit         sel_b;
  ctl_t       q[$];
  vec_t       vt[$];
  int         n_checks, n_err;

  slc3_isdu_param #(.MEM_WAIT(2), .PAUSE_EN(1'b1)) u_a (
    .Clk(Clk), .Reset(Reset), .run_i(run), .continue_i(cont), .opcode_i(opcode),
    .ir_5_i(ir5), .ir_11_i(ir11), .ben_i(ben),
    .ld_mar_o(oa.ld_mar), .ld_mdr_o(oa.ld_mdr), .ld_ir_o(oa.ld_ir), .ld_ben_o(oa.ld_ben),
    .ld_cc_o(oa.ld_cc), .ld_reg_o(oa.ld_reg), .ld_pc_o(oa.ld_pc), .ld_led_o(oa.ld_led),
    .gate_pc_o(oa.gate_pc), .gate_mdr_o(oa.gate_mdr), .gate_alu_o(oa.gate_alu),
    .gate_marmux_o(oa.gate_marmux), .pcmux_o(oa.pcmux), .drmux_o(oa.drmux),
    .sr1mux_o(oa.sr1mux), .sr2mux_o(oa.sr2mux), .addr1mux_o(oa.addr1mux),
    .addr2mux_o(oa.addr2mux), .aluk_o(oa.aluk), .mem_oe_o(oa.mem_oe), .mem_we_o(oa.mem_we),
    .busy_o(oa.busy)
  );

  slc3_isdu_param #(.MEM_WAIT(3), .PAUSE_EN(1'b0)) u_b (
    .Clk(Clk), .Reset(Reset), .run_i(run), .continue_i(cont), .opcode_i(opcode),
    .ir_5_i(ir5), .ir_11_i(ir11), .ben_i(ben),
    .ld_mar_o(ob.ld_mar), .ld_mdr_o(ob.ld_mdr), .ld_ir_o(ob.ld_ir), .ld_ben_o(ob.ld_ben),
    .ld_cc_o(ob.ld_cc), .ld_reg_o(ob.ld_reg), .ld_pc_o(ob.ld_pc), .ld_led_o(ob.ld_led),
    .gate_pc_o(ob.gate_pc), .gate_mdr_o(ob.gate_mdr), .gate_alu_o(ob.gate_alu),
    .gate_marmux_o(ob.gate_marmux), .pcmux_o(ob.pcmux), .drmux_o(ob.drmux),
    .sr1mux_o(ob.sr1mux), .sr2mux_o(ob.sr2mux), .addr1mux_o(ob.addr1mux),
    .addr2mux_o(ob.addr2mux), .aluk_o(ob.aluk), .mem_oe_o(ob.mem_oe), .mem_we_o(ob.mem_we),
    .busy_o(ob.busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Expected control word for one state tag, written from the control table.
  function automatic ctl_t exp_ctl(input tag_e t, input logic i5);
    ctl_t c;
    c = '0;
    c.busy = 1'b1;
    case (t)
      TH:   c.busy = 1'b0;
      T18:  begin c.gate_pc = 1; c.ld_mar = 1; c.ld_pc = 1; end
      TFM:  c.mem_oe = 1;
      TFML: begin c.mem_oe = 1; c.ld_mdr = 1; end
      T35:  begin c.gate_mdr = 1; c.ld_ir = 1; end
      T32:  c.ld_ben = 1;
      TADD: begin c.sr1mux = 1; c.sr2mux = i5; c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1; end
      TAND: begin
        c.sr1mux = 1; c.sr2mux = i5; c.aluk = 2'b01; c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1;
      end
      TNOT: begin c.sr1mux = 1; c.aluk = 2'b10; c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1; end
      TE22: begin c.addr2mux = 2'b10; c.pcmux = 2'b10; c.ld_pc = 1; end
      TJMP: begin c.sr1mux = 1; c.aluk = 2'b11; c.gate_alu = 1; c.pcmux = 2'b01; c.ld_pc = 1; end
      TE04: begin c.gate_pc = 1; c.drmux = 1; c.ld_reg = 1; end
      TE21: begin c.addr2mux = 2'b11; c.pcmux = 2'b10; c.ld_pc = 1; end
      TE20: begin c.sr1mux = 1; c.addr1mux = 1; c.pcmux = 2'b10; c.ld_pc = 1; end
      TE06, TE07: begin
        c.sr1mux = 1; c.addr1mux = 1; c.addr2mux = 2'b01; c.gate_marmux = 1; c.ld_mar = 1;
      end
      TLM:  c.mem_oe = 1;
      TLML: begin c.mem_oe = 1; c.ld_mdr = 1; end
      TE27: begin c.gate_mdr = 1; c.ld_reg = 1; c.ld_cc = 1; end
      TE23: begin c.aluk = 2'b11; c.gate_alu = 1; c.ld_mdr = 1; end
      TSM:  c.mem_we = 1;
      TP1:  begin c.ld_led = 1; c.busy = 0; end
      TP2:  c.busy = 0;
      default: c.busy = 0;
    endcase
    return c;
  endfunction

  task automatic push(input tag_e t);
    q.push_back(exp_ctl(t, ir5));
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  // Pop one expected word and compare against the selected DUT, plus bus/strobe exclusivity.
  task automatic check_pop(input string name);
    ctl_t exp, act;
    act = sel_b ? ob : oa;
    n_checks++;
    if (q.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty, got %h", name, act);
    end else begin
      exp = q.pop_front();
      if (act !== exp) begin
        n_err++;
        $display("FAIL %s: got %h required %h", name, act, exp);
      end
    end
    n_checks++;
    if ($countones({act.gate_pc, act.gate_mdr, act.gate_alu, act.gate_marmux}) > 1 ||
        (act.mem_oe && act.mem_we)) begin
      n_err++;
      $display("FAIL %s_excl: gates=%b oe=%b we=%b required one-hot/none, not both strobes",
               name, {act.gate_pc, act.gate_mdr, act.gate_alu, act.gate_marmux},
               act.mem_oe, act.mem_we);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    repeat (3) tick();
    Reset = 1'b0;
  endtask

  task automatic add_vec(input string nm, input logic [3:0] op, input logic i5, input logic i11,
                         input logic b, input tag_e e0, input tag_e e1, input tag_e e2,
                         input int n, input bit tf);
    vec_t v;
    v.name = nm; v.op = op; v.ir5 = i5; v.ir11 = i11; v.ben = b;
    v.ex[0] = e0; v.ex[1] = e1; v.ex[2] = e2; v.ex[3] = TH;
    v.n_ex = n; v.to_fetch = tf;
    vt.push_back(v);
  endtask

  // Reset, run one instruction from HALTED and check every cycle until back in fetch.
  task automatic run_vec(input vec_t v, input int mw);
    int n;
    do_reset();
    opcode = v.op; ir5 = v.ir5; ir11 = v.ir11; ben = v.ben;
    push(TH);
    push(T18);
    for (int k = 0; k < mw; k++) push((k == mw - 1) ? TFML : TFM);
    push(T35);
    push(T32);
    for (int e = 0; e < v.n_ex; e++) begin
      if (v.ex[e] == TLMX) begin
        for (int k = 0; k < mw; k++) push((k == mw - 1) ? TLML : TLM);
      end else if (v.ex[e] == TSMX) begin
        for (int k = 0; k < mw; k++) push(TSM);
      end else begin
        push(v.ex[e]);
      end
    end
    if (v.to_fetch) push(T18);
    n = q.size();
    for (int i = 0; i < n; i++) begin
      check_pop($sformatf("%s_c%0d", v.name, i));
      if (i == 0) run = 1'b1;
      if (i == 1) run = 1'b0;
      if (i < n - 1) tick();
    end
  endtask

  initial begin
    n_checks = 0; n_err = 0; sel_b = 1'b0;
    Reset = 1'b1; run = 1'b0; cont = 1'b0; opcode = 4'b0000; ir5 = 0; ir11 = 0; ben = 0;
    @(negedge Clk);

    add_vec("add_reg", 4'b0001, 0, 0, 0, TADD, TH, TH, 1, 1);
    add_vec("add_imm", 4'b0001, 1, 0, 0, TADD, TH, TH, 1, 1);
    add_vec("and_imm", 4'b0101, 1, 0, 0, TAND, TH, TH, 1, 1);
    add_vec("not",     4'b1001, 0, 0, 0, TNOT, TH, TH, 1, 1);
    add_vec("br_nt",   4'b0000, 0, 0, 0, TH,   TH, TH, 0, 1);
    add_vec("br_t",    4'b0000, 0, 0, 1, TE22, TH, TH, 1, 1);
    add_vec("jmp",     4'b1100, 0, 0, 0, TJMP, TH, TH, 1, 1);
    add_vec("jsr",     4'b0100, 0, 1, 0, TE04, TE21, TH, 2, 1);
    add_vec("jsrr",    4'b0100, 0, 0, 0, TE04, TE20, TH, 2, 1);
    add_vec("ldr",     4'b0110, 0, 0, 0, TE06, TLMX, TE27, 3, 1);
    add_vec("str",     4'b0111, 0, 0, 0, TE07, TE23, TSMX, 3, 1);
    add_vec("nop1010", 4'b1010, 0, 0, 0, TH,   TH, TH, 0, 1);

    foreach (vt[i]) run_vec(vt[i], 2);

    // Reset mid-fetch access: HALTED with all outputs low on each reset cycle.
    do_reset();
    opcode = 4'b0001;
    push(TH); check_pop("rst_idle");
    tick(); push(TH); check_pop("rst_run_low");
    run = 1'b1; tick(); push(T18); check_pop("rst_f18");
    run = 1'b0; tick(); push(TFM); check_pop("rst_fmem");
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); push(TH); check_pop($sformatf("rst_hold%0d", i)); end
    Reset = 1'b0;
    tick(); push(TH); check_pop("rst_after");

    // PAUSE handshake: LED held until Continue, PAUSE2 while Continue high.
    begin
      vec_t v;
      v.name = "pause"; v.op = 4'b1101; v.ir5 = 0; v.ir11 = 0; v.ben = 0;
      v.ex[0] = TP1; v.ex[1] = TH; v.ex[2] = TH; v.ex[3] = TH; v.n_ex = 1; v.to_fetch = 0;
      run_vec(v, 2);
    end
    for (int i = 0; i < 5; i++) begin tick(); push(TP1); check_pop($sformatf("p1_hold%0d", i)); end
    cont = 1'b1;
    tick(); push(TP2); check_pop("p2_enter");
    tick(); push(TP2); check_pop("p2_hold");
    cont = 1'b0;
    tick(); push(T18); check_pop("p2_exit");

    // Second instance: three-cycle SRAM and PAUSE disabled.
    sel_b = 1'b1;
    begin
      vec_t v;
      v.ir11 = 0; v.ben = 0; v.ex[1] = TH; v.ex[2] = TH; v.ex[3] = TH; v.to_fetch = 1;
      v.name = "w3_add_imm"; v.op = 4'b0001; v.ir5 = 1; v.ex[0] = TADD; v.n_ex = 1;
      run_vec(v, 3);
      v.name = "w3_pause_nop"; v.op = 4'b1101; v.ir5 = 0; v.n_ex = 0;
      run_vec(v, 3);
      v.name = "w3_ldr"; v.op = 4'b0110; v.ex[0] = TE06; v.ex[1] = TLMX; v.ex[2] = TE27;
      v.n_ex = 3;
      run_vec(v, 3);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
